// File: rtl/logic_op_pkg.sv
// Shared opcode encodings for the bitwise logic unit and its arbiter.
package logic_op_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_AND = 2'b00;
  localparam logic [OP_W-1:0] OP_OR  = 2'b01;
  localparam logic [OP_W-1:0] OP_NOT = 2'b10;
  localparam logic [OP_W-1:0] OP_XOR = 2'b11;

endpackage

// File: rtl/logic_vec_unit.sv
// Combinational DATA_W-bit bitwise unit: AND, OR, NOT (of a), XOR.
module logic_vec_unit
  import logic_op_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit among NUM_REQ
// valid/ready requesters, with a single backpressured result register.
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [NUM_REQ-1:0]        req_valid_in,
  output logic [NUM_REQ-1:0]        req_ready_out,
  input  logic [OP_W*NUM_REQ-1:0]   req_op_in,
  input  logic [DATA_W*NUM_REQ-1:0] req_a_in,
  input  logic [DATA_W*NUM_REQ-1:0] req_b_in,
  output logic                      res_valid_out,
  input  logic                      res_ready_in,
  output logic [DATA_W-1:0]         res_data_out,
  output logic [ID_W-1:0]           res_id_out,
  output logic [OP_W-1:0]           res_op_out,
  output logic [CNT_W-1:0]          xfer_count_out
);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    nxt_ptr;
  logic [ID_W-1:0]    gnt_id;
  logic [NUM_REQ-1:0] gnt;
  logic               found;
  logic               can_accept;
  logic               xfer;
  logic [OP_W-1:0]    sel_op;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic [DATA_W-1:0]  unit_y;
  int unsigned        idx;

  assign can_accept = !res_valid_out || res_ready_in;

  // Search starts at ptr and wraps; operands of the winner are muxed alongside
  // but never influence the grant itself.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    nxt_ptr = '0;
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (k + 32'(ptr)) % NUM_REQ;
      if (!found && req_valid_in[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
        nxt_ptr  = ID_W'((idx + 1) % NUM_REQ);
        sel_op   = req_op_in[idx*OP_W +: OP_W];
        sel_a    = req_a_in[idx*DATA_W +: DATA_W];
        sel_b    = req_b_in[idx*DATA_W +: DATA_W];
      end
    end
    if (!(can_accept && rst_n_in)) gnt = '0;
  end

  assign req_ready_out = gnt;
  assign xfer          = |gnt;

  logic_vec_unit #(
    .DATA_W(DATA_W)
  ) u_unit (
    .op(sel_op),
    .a (sel_a),
    .b (sel_b),
    .y (unit_y)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr            <= '0;
      res_valid_out  <= 1'b0;
      res_data_out   <= '0;
      res_id_out     <= '0;
      res_op_out     <= '0;
      xfer_count_out <= '0;
    end else if (xfer) begin
      ptr            <= nxt_ptr;
      res_valid_out  <= 1'b1;
      res_data_out   <= unit_y;
      res_id_out     <= gnt_id;
      res_op_out     <= sel_op;
      xfer_count_out <= xfer_count_out + 1'b1;
    end else if (res_ready_in) begin
      res_valid_out  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Scoreboard bench for logic_op_arbiter: accepted requests are predicted at the
// handshake and compared against the result register one cycle later.
module tb_logic_op_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned CNT_W   = 4;

  logic                      clk_in = 1'b0;
  logic                      rst_n_in;
  logic [NUM_REQ-1:0]        req_valid_in;
  logic [NUM_REQ-1:0]        req_ready_out;
  logic [2*NUM_REQ-1:0]      req_op_in;
  logic [DATA_W*NUM_REQ-1:0] req_a_in;
  logic [DATA_W*NUM_REQ-1:0] req_b_in;
  logic                      res_valid_out;
  logic                      res_ready_in;
  logic [DATA_W-1:0]         res_data_out;
  logic [ID_W-1:0]           res_id_out;
  logic [1:0]                res_op_out;
  logic [CNT_W-1:0]          xfer_count_out;

  logic_op_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_op_in     (req_op_in),
    .req_a_in      (req_a_in),
    .req_b_in      (req_b_in),
    .res_valid_out (res_valid_out),
    .res_ready_in  (res_ready_in),
    .res_data_out  (res_data_out),
    .res_id_out    (res_id_out),
    .res_op_out    (res_op_out),
    .xfer_count_out(xfer_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [1:0]        op;
    logic [DATA_W-1:0] data;
  } exp_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] model(input logic [1:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~a;
      default: return a ^ b;
    endcase
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  exp_t               q[$];
  exp_t               last;
  logic               mval;
  logic               xfer_prev;
  logic               rdy_prev;
  logic [CNT_W-1:0]   exp_cnt;
  logic [NUM_REQ-1:0] pv, pacc;
  logic [2*NUM_REQ-1:0]      p_op;
  logic [DATA_W*NUM_REQ-1:0] p_a, p_b;

  initial begin
    last = '0; mval = 1'b0; xfer_prev = 1'b0; rdy_prev = 1'b0; exp_cnt = '0;
    pv = '0; pacc = '0; p_op = '0; p_a = '0; p_b = '0;
  end

  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      q.delete();
      last = '0; mval = 1'b0; xfer_prev = 1'b0; exp_cnt = '0; pv = '0; pacc = '0;
    end else begin
      if (xfer_prev) begin
        if (q.size() == 0) check("sb_underflow", 32'(q.size()), 1);
        else begin
          last = q.pop_front();
          mval = 1'b1;
        end
      end else if (mval && rdy_prev) begin
        mval = 1'b0;
      end
      check("res_valid", 32'(res_valid_out), 32'(mval));
      check("res_data",  32'(res_data_out),  32'(last.data));
      check("res_id",    32'(res_id_out),    32'(last.id));
      check("res_op",    32'(res_op_out),    32'(last.op));
      check("xfer_count", 32'(xfer_count_out), 32'(exp_cnt));
      check("ready_onehot", 32'($countones(req_ready_out) <= 1), 1);
      if (mval && !res_ready_in) check("hold_no_grant", 32'(req_ready_out), 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pv[i] && !pacc[i])
          check("req_protocol",
                32'(req_valid_in[i] && req_op_in[2*i +: 2] == p_op[2*i +: 2] &&
                    req_a_in[DATA_W*i +: DATA_W] == p_a[DATA_W*i +: DATA_W] &&
                    req_b_in[DATA_W*i +: DATA_W] == p_b[DATA_W*i +: DATA_W]), 1);
      end
      xfer_prev = 1'b0;
      rdy_prev  = res_ready_in;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid_in[i] && req_ready_out[i]) begin
          q.push_back('{id: ID_W'(i), op: req_op_in[2*i +: 2],
                        data: model(req_op_in[2*i +: 2], req_a_in[DATA_W*i +: DATA_W],
                                    req_b_in[DATA_W*i +: DATA_W])});
          exp_cnt   = exp_cnt + 1'b1;
          xfer_prev = 1'b1;
        end
      end
      pv   = req_valid_in;
      pacc = req_valid_in & req_ready_out;
      p_op = req_op_in;
      p_a  = req_a_in;
      p_b  = req_b_in;
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    req_valid_in[i]              = 1'b1;
    req_op_in[2*i +: 2]          = op;
    req_a_in[DATA_W*i +: DATA_W] = a;
    req_b_in[DATA_W*i +: DATA_W] = b;
  endtask

  task automatic clr_req(input int i);
    req_valid_in[i] = 1'b0;
  endtask

  // Drops each request only after it has been accepted.
  task automatic drain_reqs();
    int unsigned        n;
    logic [NUM_REQ-1:0] acc;
    n = 0;
    while (req_valid_in != '0 && n < 32) begin
      #1;
      acc = req_valid_in & req_ready_out;
      cyc();
      req_valid_in = req_valid_in & ~acc;
      n++;
    end
    check("drain_timeout", 32'(req_valid_in), 0);
  endtask

  logic [NUM_REQ-1:0] seq [5];
  int unsigned        nf;
  logic [CNT_W-1:0]   prev_cnt, cur_cnt;
  logic               saw_wrap;

  initial begin
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n_in = 1'b0; res_ready_in = 1'b1;
    req_valid_in = '1; req_op_in = '0; req_a_in = '0; req_b_in = '0;
    repeat (3) cyc();
    check("rst_ready",  32'(req_ready_out), 0);
    check("rst_valid",  32'(res_valid_out), 0);
    check("rst_count",  32'(xfer_count_out), 0);
    req_valid_in = '0;
    rst_n_in = 1'b1;
    cyc();

    // Single AND request from requester 1.
    set_req(1, 2'b00, 8'hF0, 8'h3C);
    #1 check("t2_grant", 32'(req_ready_out), 32'(4'b0010));
    cyc();
    clr_req(1);
    check("t2_valid", 32'(res_valid_out), 1);
    check("t2_data",  32'(res_data_out), 32'(8'h30));
    check("t2_id",    32'(res_id_out), 1);
    check("t2_op",    32'(res_op_out), 0);
    check("t2_count", 32'(xfer_count_out), 1);
    cyc();

    // Hold a result, then reset mid-operation.
    res_ready_in = 1'b0;
    set_req(2, 2'b11, 8'hFF, 8'h0F);
    #1 check("t1_pre_grant", 32'(req_ready_out), 32'(4'b0100));
    cyc();
    clr_req(2);
    cyc();
    set_req(0, 2'b01, 8'h0F, 8'hA0);
    set_req(2, 2'b11, 8'hFF, 8'h0F);
    #1 check("t1_held_no_grant", 32'(req_ready_out), 0);
    check("t1_held_valid", 32'(res_valid_out), 1);
    rst_n_in = 1'b0;
    #1;
    check("t1_async_valid", 32'(res_valid_out), 0);
    check("t1_async_data",  32'(res_data_out), 0);
    check("t1_async_id",    32'(res_id_out), 0);
    check("t1_async_op",    32'(res_op_out), 0);
    check("t1_async_count", 32'(xfer_count_out), 0);
    check("t1_async_ready", 32'(req_ready_out), 0);
    cyc();
    rst_n_in = 1'b1;
    res_ready_in = 1'b1;
    #1 check("t1_ptr0_grant", 32'(req_ready_out), 32'(4'b0001));

    // All four continuously valid: round-robin 0,1,2,3,0.
    set_req(1, 2'b10, 8'h55, 8'h00);
    set_req(3, 2'b00, 8'hF0, 8'h3C);
    for (int k = 0; k < 5; k++) begin
      #1 check("t3_rr_grant", 32'(req_ready_out), 32'(seq[k]));
      cyc();
    end
    check("t3_last_data", 32'(res_data_out), 32'(8'hAF));

    // Backpressure for three cycles, then release.
    res_ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("t4_bp_ready", 32'(req_ready_out), 0);
      check("t4_bp_data", 32'(res_data_out), 32'(8'hAF));
      check("t4_bp_id",   32'(res_id_out), 0);
      cyc();
    end
    res_ready_in = 1'b1;
    #1 check("t4_release_grant", 32'(req_ready_out), 32'(4'b0010));
    cyc();
    check("t4_nobubble_valid", 32'(res_valid_out), 1);
    check("t4_nobubble_data",  32'(res_data_out), 32'(8'hAA));
    check("t4_nobubble_id",    32'(res_id_out), 1);
    drain_reqs();
    cyc();

    // Fairness: req0 always valid, req3 raised once.
    set_req(0, 2'b01, 8'h0F, 8'hA0);
    #1 check("t5_req0_grant", 32'(req_ready_out), 32'(4'b0001));
    cyc();
    set_req(3, 2'b00, 8'hF0, 8'h3C);
    nf = 0;
    #1;
    while (!req_ready_out[3] && nf < 8) begin
      cyc();
      nf++;
    end
    check("t5_fair_bound", 32'(nf < NUM_REQ), 1);
    cyc();
    clr_req(3);
    set_req(1, 2'b10, 8'h55, 8'h00);
    set_req(2, 2'b11, 8'hFF, 8'h0F);
    #1 check("t5_ptr0_grant", 32'(req_ready_out), 32'(4'b0001));
    drain_reqs();
    cyc();

    // Counter wrap at CNT_W=4: 17 back-to-back transfers.
    saw_wrap = 1'b0;
    prev_cnt = xfer_count_out;
    set_req(0, 2'b11, 8'h5A, 8'hFF);
    for (int k = 0; k < 17; k++) begin
      cyc();
      cur_cnt = xfer_count_out;
      if (prev_cnt == 4'hF) begin
        check("t6_wrap_to_0", 32'(cur_cnt), 0);
        saw_wrap = 1'b1;
      end
      prev_cnt = cur_cnt;
      if (k < 16) set_req(0, 2'(k), 8'(8'h11 * k), 8'(8'hC3 ^ k));
      else clr_req(0);
    end
    check("t6_wrap_seen", 32'(saw_wrap), 1);
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shares one registered DATA_W-bit bitwise logic unit (AND / OR / NOT / XOR) among NUM_REQ requesters.
- Arbitration is round-robin. Each requester uses a valid/ready handshake. The result is a single registered output stage with valid/ready backpressure.
- Sits between the requesting controllers and the downstream consumer of logic results. Peak throughput is one operation per cycle.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand/result width.
- ID_W, 2, requester-index width; must be >= clog2(NUM_REQ).
- CNT_W, 16, completed-transfer counter width.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  reset; asynchronous assert, active-low.
- req_valid_in  input  NUM_REQ  per-requester request valid.
- req_ready_out  output  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_op_in  input  2*NUM_REQ  opcode of requester i in bits [2i+1:2i].
- req_a_in  input  DATA_W*NUM_REQ  operand A of requester i in slice i.
- req_b_in  input  DATA_W*NUM_REQ  operand B of requester i in slice i.
- res_valid_out  output  1  result register holds valid data.
- res_ready_in  input  1  consumer accepts the result.
- res_data_out  output  DATA_W  result.
- res_id_out  output  ID_W  index of the requester that produced the result.
- res_op_out  output  2  opcode of the result.
- xfer_count_out  output  CNT_W  number of accepted requests; wraps.

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - res_valid_out=0, res_data_out=0, res_id_out=0, res_op_out=0, xfer_count_out=0.
  - Round-robin pointer ptr=0.
  - req_ready_out=0 while in reset.
- Opcodes:
  - 00 AND: a & b.
  - 01 OR: a | b.
  - 10 NOT: ~a, b ignored.
  - 11 XOR: a ^ b.
  - All bitwise, DATA_W wide, no carries.
- can_accept = !res_valid_out || res_ready_in.
- Arbitration (combinational, same cycle):
  - If can_accept, grant the first i with req_valid_in[i]=1, searching ptr, ptr+1, ... mod NUM_REQ.
  - req_ready_out[i]=1 for the granted requester only; all zero if can_accept=0 or there are no requests.
  - req_ready_out may depend on req_valid_in. It never depends on operand values.
- Transfer occurs when req_valid_in[i] && req_ready_out[i]. On the next edge:
  - res_data_out <= op(a_i, b_i); res_id_out <= i; res_op_out <= op_i; res_valid_out <= 1.
  - ptr <= (i+1) mod NUM_REQ.
  - xfer_count_out <= xfer_count_out + 1, wrapping at 2^CNT_W.
- Latency: one cycle from accept to res_valid_out.
- Output hold: while res_valid_out && !res_ready_in, every res_* output stays stable and no grant is issued.
- Drain without a new accept: res_valid_out <= 0. Data, id and op keep their last values.
- Simultaneous drain and accept: the new result replaces the old one, with no bubble.
- ptr advances only on a transfer.
- Fairness: a requester holding valid is granted within NUM_REQ transfers.
- Requester protocol:
  - Once raised, req_valid_in[i] and its op/a/b stay stable until accepted.
  - The block does not check this; the bench asserts it.
- Reset mid-operation: any pending result is discarded immediately and the pointer returns to 0.

Decomposition:
- Package logic_op_pkg:
  - Opcode localparams OP_AND=2'b00, OP_OR=2'b01, OP_NOT=2'b10, OP_XOR=2'b11.
  - OP_W=2.
- Sub-module logic_vec_unit: combinational DATA_W-bit bitwise unit (op, a, b -> y).
- Arbiter, pointer, output register and counter live in logic_op_arbiter.

Test Plan:
1. Reset: drive rst_n_in low mid-run with res_valid_out=1 -> all outputs 0 asynchronously. Release, then raise req2 and req0 together -> req0 granted first (ptr=0).
2. Single request: req1 AND, a=8'hF0, b=8'h3C -> req_ready_out=4'b0010 in the same cycle. Next cycle: res_valid_out=1, res_data_out=8'h30, res_id_out=1, res_op_out=00, xfer_count_out=1.
3. All four requesters continuously valid, res_ready_in=1 -> grant order 0,1,2,3,0 at one per cycle. Expected results:
   - OR 8'h0F|8'hA0 = 8'hAF.
   - NOT a=8'h55 -> 8'hAA.
   - XOR 8'hFF^8'h0F = 8'hF0.
4. Backpressure: res_ready_in low for 3 cycles with a result held -> req_ready_out=0, res_* stable, count unchanged. Raise res_ready_in -> the next requester is granted in that same cycle and its result appears on the following edge with no bubble.
5. Fairness: req0 always valid while req3 is raised once -> req3 granted within 4 transfers, and the pointer is then 0.
6. Counter wrap with CNT_W=4: 17 transfers -> xfer_count_out goes 15 -> 0 -> 1.
